dmem_port_scheduler: RTL and testbench

- Shares one single-port synchronous data memory between the two issue slots of the dual-issue pipeline in the MEM stage.
- When both slots access memory in the same cycle, it serializes them: slot 1 goes first, then slot 2. While it does so it raises a one-cycle pipeline stall.
- Same-address pairs are merged with no stall: read/read uses one read, write/write keeps only slot 2's write, and write1/read2 forwards slot 1's data.
- Read data is returned per slot with valid pulses. A saturating counter records how many conflicts were serialized.

---
 rtl/dmem_port_scheduler.sv | 166 ++++++++++++++++
 tb/tb_dmem_port_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_scheduler.sv
// Arbitrates the two MEM-stage issue slots onto one single-port synchronous data memory.
// Same-address pairs are merged in one cycle; other concurrent pairs are serialized (slot 1 first).
module dmem_port_scheduler #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rd1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              rd2,
    input  logic              wr2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic              stall,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid1,
    output logic              rvalid2,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // state  | meaning
    // IDLE   | accept live slot requests, merge or start serialization
    // SERVE2 | issue the buffered slot 2 access, live inputs ignored
    typedef enum logic {IDLE, SERVE2} stateT;

    stateT state, nextState;

    logic              rdEff1, rdEff2, req1, req2, sameAddr;
    logic              mergeRR, mergeWW, mergeWR, conflict;
    logic              issueTag1, issueTag2, issueFwd, capture;
    logic              tag1, tag2, fwdPend;
    logic [DATA_W-1:0] fwdData;
    logic              pendRd, pendWr;
    logic [ADDR_W-1:0] pendAddr;
    logic [DATA_W-1:0] pendWdata;

    // A slot asserting both rd and wr is treated as a store.
    assign rdEff1   = rd1 & ~wr1;
    assign rdEff2   = rd2 & ~wr2;
    assign req1     = rd1 | wr1;
    assign req2     = rd2 | wr2;
    assign sameAddr = (addr1 == addr2);
    assign mergeRR  = rdEff1 & rdEff2 & sameAddr;
    assign mergeWW  = wr1 & wr2 & sameAddr;
    assign mergeWR  = wr1 & rdEff2 & sameAddr;
    assign conflict = req1 & req2 & ~(mergeRR | mergeWW | mergeWR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (enable) begin
            case (state)
                IDLE:    if (conflict) nextState = SERVE2;
                SERVE2:  nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        stall     = 1'b0;
        issueTag1 = 1'b0;
        issueTag2 = 1'b0;
        issueFwd  = 1'b0;
        capture   = 1'b0;
        if (enable && !rst) begin
            case (state)
                IDLE: begin
                    if (req1 && !req2) begin
                        mem_rden  = rdEff1;
                        mem_wren  = wr1;
                        issueTag1 = rdEff1;
                    end else if (req2 && !req1) begin
                        mem_addr  = addr2;
                        mem_wdata = wdata2;
                        mem_rden  = rdEff2;
                        mem_wren  = wr2;
                        issueTag2 = rdEff2;
                    end else if (mergeRR) begin
                        mem_rden  = 1'b1;
                        issueTag1 = 1'b1;
                        issueTag2 = 1'b1;
                    end else if (mergeWW) begin
                        mem_wdata = wdata2;
                        mem_wren  = 1'b1;
                    end else if (mergeWR) begin
                        mem_wren  = 1'b1;
                        issueFwd  = 1'b1;
                    end else if (conflict) begin
                        mem_rden  = rdEff1;
                        mem_wren  = wr1;
                        issueTag1 = rdEff1;
                        stall     = 1'b1;
                        capture   = 1'b1;
                    end
                end
                SERVE2: begin
                    mem_addr  = pendAddr;
                    mem_wdata = pendWdata;
                    mem_rden  = pendRd;
                    mem_wren  = pendWr;
                    issueTag2 = pendRd;
                end
                default: ;
            endcase
        end
    end

    // Read-return tags only advance while enabled, so a frozen pipeline defers the capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag1         <= 1'b0;
            tag2         <= 1'b0;
            fwdPend      <= 1'b0;
            fwdData      <= '0;
            pendRd       <= 1'b0;
            pendWr       <= 1'b0;
            pendAddr     <= '0;
            pendWdata    <= '0;
            rdata1       <= '0;
            rdata2       <= '0;
            conflict_cnt <= '0;
        end else if (enable) begin
            tag1    <= issueTag1;
            tag2    <= issueTag2;
            fwdPend <= issueFwd;
            if (issueFwd) fwdData <= wdata1;
            if (capture) begin
                pendRd    <= rdEff2;
                pendWr    <= wr2;
                pendAddr  <= addr2;
                pendWdata <= wdata2;
                if (!(&conflict_cnt)) conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
            if (tag1) rdata1 <= mem_q;
            if (tag2) rdata2 <= mem_q;
            else if (fwdPend) rdata2 <= fwdData;
        end
    end

    assign rvalid1 = enable & tag1;
    assign rvalid2 = enable & (tag2 | fwdPend);

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Directed bench for dmem_port_scheduler with a behavioural single-port synchronous memory.
module tb_dmem_port_scheduler;

    logic        clk = 1'b0;
    logic        rst, enable, enNext;
    logic        rd1, wr1, rd2, wr2;
    logic [10:0] addr1, addr2;
    logic [31:0] wdata1, wdata2;
    logic [31:0] memQ;
    logic [10:0] memAddr;
    logic [31:0] memWdata;
    logic        memRden, memWren, stall;
    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2;
    logic [15:0] conflictCnt;

    logic [10:0] satAddr;
    logic [31:0] satWdata, satRdata1, satRdata2;
    logic        satRden, satWren, satStall, satRvalid1, satRvalid2;
    logic [2:0]  satCnt;

    logic [31:0] mem [0:2047];

    int vecCnt = 0;
    int errCnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWren) mem[memAddr] <= memWdata;
        if (memRden) memQ <= mem[memAddr];
    end

    dmem_port_scheduler dut (
        .clk(clk), .rst(rst), .enable(enable),
        .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .rd2(rd2), .wr2(wr2), .addr2(addr2), .wdata2(wdata2),
        .mem_q(memQ), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rden(memRden), .mem_wren(memWren), .stall(stall),
        .rdata1(rdata1), .rdata2(rdata2), .rvalid1(rvalid1), .rvalid2(rvalid2),
        .conflict_cnt(conflictCnt)
    );

    // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly.
    dmem_port_scheduler #(.CNT_W(3)) satDut (
        .clk(clk), .rst(rst), .enable(enable),
        .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .rd2(rd2), .wr2(wr2), .addr2(addr2), .wdata2(wdata2),
        .mem_q(memQ), .mem_addr(satAddr), .mem_wdata(satWdata),
        .mem_rden(satRden), .mem_wren(satWren), .stall(satStall),
        .rdata1(satRdata1), .rdata2(satRdata2), .rvalid1(satRvalid1), .rvalid2(satRvalid2),
        .conflict_cnt(satCnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r1, input logic w1, input logic [10:0] a1, input logic [31:0] d1,
                        input logic r2, input logic w2, input logic [10:0] a2, input logic [31:0] d2);
        @(negedge clk);
        enable = enNext;
        rd1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
        rd2 = r2; wr2 = w2; addr2 = a2; wdata2 = d2;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; enNext = 1'b1;
        rd1 = 1'b1; wr1 = 1'b0; addr1 = 11'd5; wdata1 = '0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
        #3;
        checkVal("rst_rden", {31'b0, memRden}, 32'd0);
        checkVal("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
        checkVal("rst_rdata1", rdata1, 32'd0);
        checkVal("rst_cnt", {16'b0, conflictCnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd1 = 1'b0;

        step(1'b0, 1'b1, 11'd5, 32'hDEAD, 1'b0, 1'b0, 11'd0, 32'h0);
        step(1'b0, 1'b1, 11'd3, 32'h11, 1'b0, 1'b0, 11'd0, 32'h0);
        step(1'b0, 1'b0, 11'd0, 32'h0, 1'b0, 1'b1, 11'd7, 32'h22);
        step(1'b0, 1'b1, 11'd6, 32'h1, 1'b0, 1'b0, 11'd0, 32'h0);
        step(1'b0, 1'b1, 11'd10, 32'hAB, 1'b0, 1'b0, 11'd0, 32'h0);
        checkVal("pre_stall", {31'b0, stall}, 32'd0);

        // single read
        step(1'b1, 1'b0, 11'd5, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
        checkVal("rd_rden", {31'b0, memRden}, 32'd1);
        checkVal("rd_addr", {21'b0, memAddr}, 32'd5);
        checkVal("rd_stall", {31'b0, stall}, 32'd0);
        idle();
        checkVal("rd_rvalid1", {31'b0, rvalid1}, 32'd1);
        idle();
        checkVal("rd_rdata1", rdata1, 32'hDEAD);
        checkVal("rd_rvalid1_end", {31'b0, rvalid1}, 32'd0);

        // same-address read/read merge
        step(1'b1, 1'b0, 11'd5, 32'h0, 1'b1, 1'b0, 11'd5, 32'h0);
        checkVal("rr_rden", {31'b0, memRden}, 32'd1);
        checkVal("rr_stall", {31'b0, stall}, 32'd0);
        idle();
        checkVal("rr_rvalid", {30'b0, rvalid1, rvalid2}, 32'd3);
        idle();
        checkVal("rr_rdata2", rdata2, 32'hDEAD);

        // conflict read/read
        step(1'b1, 1'b0, 11'd3, 32'h0, 1'b1, 1'b0, 11'd7, 32'h0);
        checkVal("c_stall", {31'b0, stall}, 32'd1);
        checkVal("c_addr0", {21'b0, memAddr}, 32'd3);
        step(1'b0, 1'b1, 11'd0, 32'h99, 1'b0, 1'b0, 11'd0, 32'h0);
        checkVal("c_addr1", {21'b0, memAddr}, 32'd7);
        checkVal("c_strobes1", {30'b0, memRden, memWren}, 32'd2);
        checkVal("c_stall1", {31'b0, stall}, 32'd0);
        checkVal("c_rvalid1", {30'b0, rvalid1, rvalid2}, 32'd2);
        checkVal("c_cnt", {16'b0, conflictCnt}, 32'd1);
        idle();
        checkVal("c_rvalid2", {30'b0, rvalid1, rvalid2}, 32'd1);
        checkVal("c_rdata1", rdata1, 32'h11);
        idle();
        checkVal("c_rdata2", rdata2, 32'h22);

        // write/write merge
        step(1'b0, 1'b1, 11'd9, 32'hA, 1'b0, 1'b1, 11'd9, 32'hB);
        checkVal("ww_strobes", {30'b0, memRden, memWren}, 32'd1);
        checkVal("ww_wdata", memWdata, 32'hB);
        checkVal("ww_addr", {21'b0, memAddr}, 32'd9);
        checkVal("ww_stall", {31'b0, stall}, 32'd0);
        step(1'b1, 1'b0, 11'd9, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
        idle();
        idle();
        checkVal("ww_readback", rdata1, 32'hB);
        checkVal("ww_cnt", {16'b0, conflictCnt}, 32'd1);

        // write1/read2 forward
        step(1'b0, 1'b1, 11'd4, 32'h55, 1'b1, 1'b0, 11'd4, 32'h0);
        checkVal("wr_strobes", {30'b0, memRden, memWren}, 32'd1);
        checkVal("wr_wdata", memWdata, 32'h55);
        checkVal("wr_stall", {31'b0, stall}, 32'd0);
        idle();
        checkVal("wr_rvalid2", {30'b0, rvalid1, rvalid2}, 32'd1);
        idle();
        checkVal("wr_rdata2", rdata2, 32'h55);
        checkVal("wr_cnt", {16'b0, conflictCnt}, 32'd1);

        // read1/write2 same address: read before write
        step(1'b1, 1'b0, 11'd6, 32'h0, 1'b0, 1'b1, 11'd6, 32'h77);
        checkVal("o_stall0", {31'b0, stall}, 32'd1);
        checkVal("o_strobes0", {30'b0, memRden, memWren}, 32'd2);
        idle();
        checkVal("o_stall1", {31'b0, stall}, 32'd0);
        checkVal("o_strobes1", {30'b0, memRden, memWren}, 32'd1);
        checkVal("o_wdata1", memWdata, 32'h77);
        checkVal("o_addr1", {21'b0, memAddr}, 32'd6);
        idle();
        checkVal("o_rdata1", rdata1, 32'h1);
        checkVal("o_stall2", {31'b0, stall}, 32'd0);
        checkVal("o_cnt", {16'b0, conflictCnt}, 32'd2);

        // enable gating during SERVE2
        step(1'b1, 1'b0, 11'd3, 32'h0, 1'b0, 1'b1, 11'd8, 32'h33);
        checkVal("e_stall0", {31'b0, stall}, 32'd1);
        enNext = 1'b0;
        idle();
        checkVal("e_off_strobes", {30'b0, memRden, memWren}, 32'd0);
        checkVal("e_off_rvalid", {30'b0, rvalid1, rvalid2}, 32'd0);
        checkVal("e_off_stall", {31'b0, stall}, 32'd0);
        idle();
        checkVal("e_off_strobes2", {30'b0, memRden, memWren}, 32'd0);
        enNext = 1'b1;
        idle();
        checkVal("e_on_strobes", {30'b0, memRden, memWren}, 32'd1);
        checkVal("e_on_addr", {21'b0, memAddr}, 32'd8);
        checkVal("e_on_wdata", memWdata, 32'h33);
        checkVal("e_on_rvalid1", {31'b0, rvalid1}, 32'd1);
        idle();
        checkVal("e_rdata1", rdata1, 32'h11);
        checkVal("e_cnt", {16'b0, conflictCnt}, 32'd3);

        // reset during SERVE2 drops the buffered write
        step(1'b1, 1'b0, 11'd3, 32'h0, 1'b0, 1'b1, 11'd10, 32'h44);
        checkVal("r_stall0", {31'b0, stall}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rd1 = 1'b0; wr2 = 1'b0; addr1 = '0; addr2 = '0; wdata2 = '0;
        #1;
        checkVal("r_strobes", {30'b0, memRden, memWren}, 32'd0);
        checkVal("r_rvalid", {30'b0, rvalid1, rvalid2}, 32'd0);
        checkVal("r_cnt", {16'b0, conflictCnt}, 32'd0);
        checkVal("r_rdata1", rdata1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("r_after_strobes", {30'b0, memRden, memWren}, 32'd0);
        step(1'b1, 1'b0, 11'd10, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
        idle();
        idle();
        checkVal("r_readback", rdata1, 32'hAB);

        // counter saturation on the narrow instance
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 11'd3, 32'h0, 1'b1, 1'b0, 11'd7, 32'h0);
            idle();
            if (i == 6) checkVal("sat_reach", {29'b0, satCnt}, 32'd7);
        end
        idle();
        checkVal("sat_hold", {29'b0, satCnt}, 32'd7);
        checkVal("sat_main_cnt", {16'b0, conflictCnt}, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
